// File: rtl/imem_dmem_port_arbiter_if.sv
// Bus bundle between the CPU core, the port arbiter and the unified memory.
//   CPU fetch port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   CPU data port  : d_req, d_wen, d_addr, d_wdata -> d_gnt, d_rvalid, d_ack, d_rdata
//   Memory port    : mem_cen, mem_wen, mem_addr, mem_wdata <- mem_rdata
//   Status         : busy
// The slave modport is the arbiter. The master modport is everything around it:
// the CPU request side and the memory model.
interface imem_dmem_port_arbiter_if #(
    parameter int unsigned AW = 32
) ();
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;

    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic          d_ack;
    logic [31:0]   d_rdata;

    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_ack, d_rdata,
        output mem_cen, mem_wen, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_ack, d_rdata,
        input  mem_cen, mem_wen, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one single-ported unified
// memory. One transaction in flight; data wins ties unless fetch has lost
// STARVE_LIMIT arbitrations in a row.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of imem_dmem_port_arbiter_if (CPU ports, memory port, busy)
module imem_dmem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                      clk,
    input logic                      rst,
    imem_dmem_port_arbiter_if.slave  bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
    localparam logic [2:0]    LatLoad   = 3'(MEM_LAT);

    typedef enum logic [1:0] {StIdle, StRdI, StRdD} state_e;

    state_e          state_q, state_d;
    logic [2:0]      lat_q, lat_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [31:0]     i_rdata_q, d_rdata_q;
    logic            d_ack_q;

    logic            final_cyc;
    logic            arb_ok;
    logic            gnt_i, gnt_d;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        starve_cnt_d = starve_cnt_q;
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;

        // The response cycle of a read frees the memory, so a new command may issue in it.
        final_cyc = (state_q != StIdle) && (lat_q == 3'd1);
        arb_ok    = (state_q == StIdle) || final_cyc;

        // Gating with rst keeps every strobe low while reset is asserted.
        if (arb_ok && !rst) begin
            if (bus.i_req && (!bus.d_req || (starve_cnt_q >= StarveMax))) begin
                gnt_i = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end
        end

        if (state_q != StIdle) begin
            lat_d = lat_q - 3'd1;
            if (final_cyc) begin
                state_d = StIdle;
            end
        end

        // Stores commit at the grant edge and leave the FSM idle.
        if (gnt_i) begin
            state_d = StRdI;
            lat_d   = LatLoad;
        end else if (gnt_d && !bus.d_wen) begin
            state_d = StRdD;
            lat_d   = LatLoad;
        end

        if (gnt_i) begin
            starve_cnt_d = '0;
        end else if (bus.i_req && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        bus.i_gnt     = gnt_i;
        bus.d_gnt     = gnt_d;
        bus.i_rvalid  = final_cyc && (state_q == StRdI);
        bus.d_rvalid  = final_cyc && (state_q == StRdD);
        bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : i_rdata_q;
        bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : d_rdata_q;
        bus.d_ack     = d_ack_q;
        bus.busy      = (state_q != StIdle);

        bus.mem_cen   = gnt_i || gnt_d;
        bus.mem_wen   = gnt_d && bus.d_wen;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_i) begin
            bus.mem_addr = bus.i_addr;
        end else if (gnt_d) begin
            bus.mem_addr = bus.d_addr;
            if (bus.d_wen) begin
                bus.mem_wdata = bus.d_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            starve_cnt_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            starve_cnt_q <= starve_cnt_d;
            d_ack_q      <= gnt_d && bus.d_wen;
            if (bus.i_rvalid) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (bus.d_rvalid) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
module tb_imem_dmem_port_arbiter;
    logic clk;
    logic rst;
    logic rst3;

    int n_checks;
    int n_fail;

    imem_dmem_port_arbiter_if #(.AW(32)) bus ();
    imem_dmem_port_arbiter_if #(.AW(32)) bus3 ();

    imem_dmem_port_arbiter #(.AW(32), .MEM_LAT(1), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    imem_dmem_port_arbiter #(.AW(32), .MEM_LAT(3), .STARVE_LIMIT(4)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A requester must hold its request until granted.
    a_i_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.i_req && !bus.i_gnt) |=> bus.i_req)
        else $error("fetch request dropped before grant");
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.d_req && !bus.d_gnt) |=> bus.d_req)
        else $error("data request dropped before grant");
    a_i_hold3: assert property (@(posedge clk) disable iff (rst3)
        (bus3.i_req && !bus3.i_gnt) |=> bus3.i_req)
        else $error("fetch request dropped before grant (lat3)");
    a_d_hold3: assert property (@(posedge clk) disable iff (rst3)
        (bus3.d_req && !bus3.d_gnt) |=> bus3.d_req)
        else $error("data request dropped before grant (lat3)");

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0]   strobes;
        logic [127:0] words;
        @(negedge clk);
        strobes = {bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid, bus.d_ack,
                   bus.mem_cen, bus.mem_wen, bus.busy};
        words   = {bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata};
        n_checks++;
        if (strobes !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_strobes: got %h want 00", strobes);
        end
        n_checks++;
        if (words !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_words: got %h want 0", words);
        end
        next_cycle();
        rst  = 1'b0;
        rst3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            strobes = {bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid, bus.d_ack,
                       bus.mem_cen, bus.mem_wen, bus.busy};
            words   = {bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata};
            n_checks++;
            if ({strobes, words} !== 136'h0) begin
                n_fail++;
                $display("FAIL idle_outputs cycle %0d: got %h/%h want 0", i, strobes, words);
            end
        end
    endtask

    task automatic test_fetch();
        next_cycle();
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0001_0000;
        bus.mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_checks++;
        if ({bus.i_gnt, bus.mem_cen, bus.mem_wen, bus.busy, bus.i_rvalid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL fetch_grant: got gnt/cen/wen/busy/rv=%b want 11000",
                     {bus.i_gnt, bus.mem_cen, bus.mem_wen, bus.busy, bus.i_rvalid});
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL fetch_addr: got %h want 00010000", bus.mem_addr);
        end
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.i_rvalid, bus.busy, bus.i_gnt} !== 3'b110 || bus.i_rdata !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_resp: got rv/busy/gnt=%b data=%h want 110 00000013",
                     {bus.i_rvalid, bus.busy, bus.i_gnt}, bus.i_rdata);
        end
        next_cycle();
        bus.mem_rdata = 32'h0000_0099;
        @(negedge clk);
        n_checks++;
        if ({bus.i_rvalid, bus.busy} !== 2'b00 || bus.i_rdata !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_hold: got rv/busy=%b data=%h want 00 00000013",
                     {bus.i_rvalid, bus.busy}, bus.i_rdata);
        end
    endtask

    task automatic test_priority();
        next_cycle();
        bus.d_req     = 1'b1;
        bus.d_wen     = 1'b0;
        bus.d_addr    = 32'hbfff_ffb8;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0001_0004;
        bus.mem_rdata = 32'hdead_beef;
        @(negedge clk);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10 || bus.mem_addr !== 32'hbfff_ffb8) begin
            n_fail++;
            $display("FAIL prio_dgnt: got d/i gnt=%b addr=%h want 10 bfffffb8",
                     {bus.d_gnt, bus.i_gnt}, bus.mem_addr);
        end
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.d_rvalid, bus.i_gnt} !== 2'b11 || bus.d_rdata !== 32'hdead_beef) begin
            n_fail++;
            $display("FAIL prio_dresp: got rv/ignt=%b data=%h want 11 deadbeef",
                     {bus.d_rvalid, bus.i_gnt}, bus.d_rdata);
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0001_0004) begin
            n_fail++;
            $display("FAIL prio_iaddr: got %h want 00010004", bus.mem_addr);
        end
        next_cycle();
        bus.i_req     = 1'b0;
        bus.mem_rdata = 32'h0000_0077;
        @(negedge clk);
        n_checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b10 || bus.i_rdata !== 32'h77 ||
            bus.d_rdata !== 32'hdead_beef) begin
            n_fail++;
            $display("FAIL prio_iresp: got i/d rv=%b idata=%h ddata=%h want 10 77 deadbeef",
                     {bus.i_rvalid, bus.d_rvalid}, bus.i_rdata, bus.d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_store();
        bus.d_req   = 1'b1;
        bus.d_wen   = 1'b1;
        bus.d_addr  = 32'h0001_0024;
        bus.d_wdata = 32'h0000_0005;
        @(negedge clk);
        n_checks++;
        if ({bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.d_ack} !== 4'b1110 ||
            bus.mem_wdata !== 32'h5 || bus.mem_addr !== 32'h0001_0024) begin
            n_fail++;
            $display("FAIL store_grant: got gnt/cen/wen/ack=%b wdata=%h addr=%h want 1110 5 10024",
                     {bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.d_ack},
                     bus.mem_wdata, bus.mem_addr);
        end
        next_cycle();
        bus.d_req = 1'b0;
        bus.d_wen = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.d_ack, bus.d_rvalid, bus.busy, bus.mem_cen} !== 4'b1000 ||
            bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_ack: got ack/rv/busy/cen=%b wdata=%h want 1000 0",
                     {bus.d_ack, bus.d_rvalid, bus.busy, bus.mem_cen}, bus.mem_wdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ack_pulse: got %b want 0", bus.d_ack);
        end
    endtask

    task automatic test_starve();
        next_cycle();
        bus.d_req  = 1'b1;
        bus.d_wen  = 1'b0;
        bus.d_addr = 32'h0000_1000;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
                n_fail++;
                $display("FAIL starve_dwin %0d: got d/i gnt=%b want 10", i,
                         {bus.d_gnt, bus.i_gnt});
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b01 || bus.mem_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL starve_iwin: got d/i gnt=%b addr=%h want 01 00002000",
                     {bus.d_gnt, bus.i_gnt}, bus.mem_addr);
        end
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.d_gnt !== 1'b1 || dut.starve_cnt_q !== 3'd0) begin
            n_fail++;
            $display("FAIL starve_clear: got dgnt=%b starve=%0d want 1 0",
                     bus.d_gnt, dut.starve_cnt_q);
        end
        next_cycle();
        bus.d_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_inflight();
        bus3.i_req     = 1'b1;
        bus3.i_addr    = 32'h0000_0200;
        bus3.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        n_checks++;
        if (bus3.i_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst3_first_gnt: got %b want 1", bus3.i_gnt);
        end
        next_cycle();
        bus3.i_req = 1'b0;
        rst3       = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus3.busy, bus3.i_rvalid} !== 2'b00 || bus3.i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst3_cleared: got busy/rv=%b data=%h want 00 0",
                     {bus3.busy, bus3.i_rvalid}, bus3.i_rdata);
        end
        next_cycle();
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus3.busy, bus3.i_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst3_no_resp %0d: got busy/rv=%b want 00", i,
                         {bus3.busy, bus3.i_rvalid});
            end
            next_cycle();
        end
        bus3.i_req     = 1'b1;
        bus3.i_addr    = 32'h0000_0300;
        bus3.mem_rdata = 32'h0000_0033;
        @(negedge clk);
        n_checks++;
        if (bus3.i_gnt !== 1'b1 || bus3.mem_addr !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL rst3_regrant: got gnt=%b addr=%h want 1 00000300",
                     bus3.i_gnt, bus3.mem_addr);
        end
        next_cycle();
        bus3.i_req  = 1'b0;
        bus3.d_req  = 1'b1;
        bus3.d_wen  = 1'b0;
        bus3.d_addr = 32'h0000_0400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus3.busy, bus3.i_rvalid, bus3.d_gnt} !== 3'b100) begin
                n_fail++;
                $display("FAIL lat3_wait %0d: got busy/rv/dgnt=%b want 100", i,
                         {bus3.busy, bus3.i_rvalid, bus3.d_gnt});
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if ({bus3.i_rvalid, bus3.d_gnt} !== 2'b11 || bus3.i_rdata !== 32'h33 ||
            bus3.mem_addr !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL lat3_resp: got rv/dgnt=%b data=%h addr=%h want 11 33 400",
                     {bus3.i_rvalid, bus3.d_gnt}, bus3.i_rdata, bus3.mem_addr);
        end
        next_cycle();
        bus3.d_req     = 1'b0;
        bus3.mem_rdata = 32'h0000_0044;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus3.d_rvalid !== 1'b1 || bus3.d_rdata !== 32'h44) begin
            n_fail++;
            $display("FAIL lat3_dresp: got rv=%b data=%h want 1 00000044",
                     bus3.d_rvalid, bus3.d_rdata);
        end
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        rst3 = 1'b1;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_req      = 1'b0;
        bus.d_wen      = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_rdata  = '0;
        bus3.i_req     = 1'b0;
        bus3.i_addr    = '0;
        bus3.d_req     = 1'b0;
        bus3.d_wen     = 1'b0;
        bus3.d_addr    = '0;
        bus3.d_wdata   = '0;
        bus3.mem_rdata = '0;

        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_starve();
        test_reset_inflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch port and the CPU load/store port, for the multi-cycle CPU variant where text, data and stack sit in one memory array.
- Serialises requests with a grant/response handshake and allows one transaction in flight.
- Gives data priority, with an aging counter so fetch cannot starve.
- Sits between the CPU core and the memory model.

Parameters:
- AW, 32, address width (byte address, word-aligned).
- MEM_LAT, 1, memory read latency in cycles (range 1..4).
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid this cycle.
- i_rdata  out  32  fetch data.
- d_req  in  1  load/store request; held with payload stable until d_gnt.
- d_wen  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid this cycle.
- d_ack  out  1  store completed (one-cycle pulse).
- d_rdata  out  32  load data.
- mem_cen  out  1  memory command strobe.
- mem_wen  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the command edge.
- busy  out  1  transaction in flight.

Behaviour:
- FSM states: IDLE, RD_I, RD_D.
- Reset (async, any cycle):
  - State goes to IDLE; latency counter and starve counter clear.
  - All strobes are 0: gnt, rvalid, d_ack, mem_cen, mem_wen, busy.
  - i_rdata, d_rdata, mem_addr and mem_wdata are 0.
  - A transaction in flight is dropped; no rvalid or ack follows reset.
- Arbitration is combinational and runs in IDLE, or in the final response cycle of RD_*.
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant I if starve_cnt >= STARVE_LIMIT, else grant D.
- Grant cycle:
  - The selected gnt is 1 for exactly one cycle.
  - mem_cen = 1; mem_addr, mem_wen and mem_wdata come from the winner. mem_wen = 0 for fetches. When idle, mem_wdata is 0.
- Load or fetch:
  - Next state is RD_D or RD_I; counter loads MEM_LAT.
  - The counter decrements each cycle.
  - In the cycle it reads 1, the matching rvalid = 1 and rdata = mem_rdata (passthrough).
  - The next state is IDLE, or a new RD_* if a new grant issues in that same cycle.
- Store:
  - The write commits at the grant edge; d_ack is a registered pulse on the following cycle.
  - The state stays IDLE, so a new grant may coincide with d_ack.
- busy = 1 while in RD_I or RD_D.
- rdata holds its last value when rvalid = 0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle i_req = 1 and i_gnt = 0.
  - Clears on i_gnt.
  - Holds while i_req = 0.
- Throughput: with MEM_LAT = 1 and continuous requests, one grant per cycle.
- Requests arriving while a read is outstanding (not in its final cycle) wait with gnt = 0.
- Dropping req before gnt is illegal; the behaviour is undefined and is flagged by a bench assertion.
- Address misalignment is not checked; the address passes through unchanged.

Test Plan:
- Reset then idle, all req = 0 for 5 cycles -> all outputs 0; mem_cen never asserted.
- i_req=1, i_addr=0x00010000, MEM_LAT=1, memory returns 0x00000013 -> i_gnt in cycle 0, i_rvalid=1 and i_rdata=0x00000013 in cycle 1, busy=1 only in cycle 1.
- Same-cycle d_req (load 0xbfffffb8 -> 0xdeadbeef) and i_req -> d_gnt first, d_rvalid with 0xdeadbeef next cycle, i_gnt in that same response cycle.
- Store d_addr=0x10024, d_wdata=0x5 -> d_gnt with mem_wen=1 and mem_wdata=0x5, d_ack one cycle later, no d_rvalid.
- d_req held high continuously with i_req high, STARVE_LIMIT=4 -> four d_gnts, then i_gnt; starve_cnt returns to 0.
- MEM_LAT=3, rst pulsed 1 cycle after a fetch grant -> no i_rvalid afterwards, state IDLE, next request granted normally.
